// File: rtl/key_debounce_pkg.sv
// key_debounce_pkg: shared types, default tick constants and counter-width
// helpers for the key debouncer.
// Optional feature macro used by this block: KEY_DEBOUNCE_REPEAT_EN.
package key_debounce_pkg;

  typedef enum logic {
    RELEASED = 1'b0,
    PRESSED  = 1'b1
  } ch_state_e;

  localparam int unsigned DEF_N_KEYS       = 4;
  localparam int unsigned DEF_TICK_DIV     = 50000;
  localparam int unsigned DEF_STABLE_TICKS = 20;
  localparam int unsigned DEF_REPEAT_DELAY = 500;
  localparam int unsigned DEF_REPEAT_RATE  = 100;

  // Bits needed to hold 0..n-1, never less than one bit.
  function automatic int unsigned width_of(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Prescaler, stability and repeat counter widths for a given configuration.
  function automatic int unsigned presc_width(input int unsigned tick_div);
    return width_of(tick_div);
  endfunction

  function automatic int unsigned stab_width(input int unsigned stable_ticks);
    return width_of(stable_ticks + 1);
  endfunction

  function automatic int unsigned rpt_width(input int unsigned delay, input int unsigned rate);
    return width_of(max_u(delay, rate));
  endfunction

endpackage

// File: rtl/key_debounce_if.sv
// key_debounce_if: key pins in, debounced levels and event pulses out.
//   key_n       raw active-low key pins (driven by master)
//   key_state   debounced level, 1 = pressed
//   key_press   one-cycle pulse on accepted press
//   key_release one-cycle pulse on accepted release
//   key_repeat  one-cycle auto-repeat pulse
// Modports: master = board/stimulus side, slave = debouncer.
interface key_debounce_if
  import key_debounce_pkg::*;
#(
  parameter int unsigned N_KEYS = DEF_N_KEYS
);

  logic [N_KEYS-1:0] key_n;
  logic [N_KEYS-1:0] key_state;
  logic [N_KEYS-1:0] key_press;
  logic [N_KEYS-1:0] key_release;
  logic [N_KEYS-1:0] key_repeat;

  modport master (
    output key_n,
    input  key_state,
    input  key_press,
    input  key_release,
    input  key_repeat
  );

  modport slave (
    input  key_n,
    output key_state,
    output key_press,
    output key_release,
    output key_repeat
  );

endinterface

// File: rtl/key_debounce_ch.sv
// key_debounce_ch: one key channel. Two-state debounce machine with a
// stability counter, press/release pulse generation and, when
// KEY_DEBOUNCE_REPEAT_EN is defined, an auto-repeat counter.
// Ports:
//   clk, nrst    clock, async active-low reset
//   tick         prescaler tick (one cycle)
//   raw_pressed  synchronized key level, 1 = pressed
//   key_state    debounced level
//   key_press    pulse on accepted press
//   key_release  pulse on accepted release
//   key_repeat   auto-repeat pulse (0 without KEY_DEBOUNCE_REPEAT_EN)
module key_debounce_ch
  import key_debounce_pkg::*;
#(
  parameter int unsigned STABLE_TICKS = DEF_STABLE_TICKS,
  parameter int unsigned REPEAT_DELAY = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_RATE  = DEF_REPEAT_RATE
) (
  input  logic clk,
  input  logic nrst,
  input  logic tick,
  input  logic raw_pressed,
  output logic key_state,
  output logic key_press,
  output logic key_release,
  output logic key_repeat
);

  localparam int unsigned STAB_W = stab_width(STABLE_TICKS);
  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_TICKS - 1);

  ch_state_e         state;
  logic [STAB_W-1:0] stab_cnt;

  assign key_state = (state == PRESSED);

  // Debounce machine: any agreement clears the counter at once; disagreement
  // must survive STABLE_TICKS ticks before the level is accepted.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state       <= RELEASED;
      stab_cnt    <= '0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
    end else begin
      key_press   <= 1'b0;
      key_release <= 1'b0;
      if (raw_pressed == key_state) begin
        stab_cnt <= '0;
      end else if (tick) begin
        if (stab_cnt == STAB_LAST) begin
          stab_cnt <= '0;
          if (state == RELEASED) begin
            state     <= PRESSED;
            key_press <= 1'b1;
          end else begin
            state       <= RELEASED;
            key_release <= 1'b1;
          end
        end else begin
          stab_cnt <= stab_cnt + STAB_W'(1);
        end
      end
    end
  end

`ifdef KEY_DEBOUNCE_REPEAT_EN
  localparam int unsigned RPT_W = rpt_width(REPEAT_DELAY, REPEAT_RATE);
  localparam logic [RPT_W-1:0] DELAY_LAST = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RATE_LAST  = RPT_W'(REPEAT_RATE - 1);

  logic [RPT_W-1:0] rpt_cnt;
  logic             rpt_phase;   // 0: waiting for first repeat, 1: periodic
  logic             rel_accept_c;

  assign rel_accept_c = tick && (state == PRESSED) && !raw_pressed && (stab_cnt == STAB_LAST);

  // Repeat counter: held clear while released (covers the press acceptance
  // cycle) and cleared without a pulse in the release acceptance cycle.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rpt_cnt    <= '0;
      rpt_phase  <= 1'b0;
      key_repeat <= 1'b0;
    end else begin
      key_repeat <= 1'b0;
      if ((state == RELEASED) || rel_accept_c) begin
        rpt_cnt   <= '0;
        rpt_phase <= 1'b0;
      end else if (tick) begin
        if (!rpt_phase && (rpt_cnt == DELAY_LAST)) begin
          key_repeat <= 1'b1;
          rpt_cnt    <= '0;
          rpt_phase  <= 1'b1;
        end else if (rpt_phase && (rpt_cnt == RATE_LAST)) begin
          key_repeat <= 1'b1;
          rpt_cnt    <= '0;
        end else begin
          rpt_cnt <= rpt_cnt + RPT_W'(1);
        end
      end
    end
  end
`else
  assign key_repeat = 1'b0;
`endif

endmodule

// File: rtl/key_debounce.sv
// key_debounce: conditions raw active-low push buttons into debounced levels
// and single-cycle press/release (and optional repeat) pulses.
// Optional feature macro: KEY_DEBOUNCE_REPEAT_EN (auto-repeat pulses).
// Ports:
//   clk   clock, rising edge
//   nrst  async active-low reset
//   bus   key_debounce_if.slave: key_n in; key_state, key_press,
//         key_release, key_repeat out
module key_debounce
  import key_debounce_pkg::*;
#(
  parameter int unsigned N_KEYS       = DEF_N_KEYS,
  parameter int unsigned TICK_DIV     = DEF_TICK_DIV,
  parameter int unsigned STABLE_TICKS = DEF_STABLE_TICKS,
  parameter int unsigned REPEAT_DELAY = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_RATE  = DEF_REPEAT_RATE
) (
  input  logic           clk,
  input  logic           nrst,
  key_debounce_if.slave  bus
);

  localparam int unsigned PRESC_W = presc_width(TICK_DIV);
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);

  logic [N_KEYS-1:0]  sync_q1;
  logic [N_KEYS-1:0]  sync_q2;
  logic [N_KEYS-1:0]  raw_pressed;
  logic [PRESC_W-1:0] presc;
  logic               tick;

  logic [N_KEYS-1:0]  state_v;
  logic [N_KEYS-1:0]  press_v;
  logic [N_KEYS-1:0]  release_v;
  logic [N_KEYS-1:0]  repeat_v;

  // Two-flop synchronizer; resets to the released pin level.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sync_q1 <= '1;
      sync_q2 <= '1;
    end else begin
      sync_q1 <= bus.key_n;
      sync_q2 <= sync_q1;
    end
  end

  assign raw_pressed = ~sync_q2;

  // Shared prescaler producing one tick every TICK_DIV cycles.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      presc <= '0;
    end else if (presc == PRESC_LAST) begin
      presc <= '0;
    end else begin
      presc <= presc + PRESC_W'(1);
    end
  end

  assign tick = (presc == PRESC_LAST);

  for (genvar i = 0; i < int'(N_KEYS); i++) begin : g_ch
    key_debounce_ch #(
      .STABLE_TICKS (STABLE_TICKS),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_RATE  (REPEAT_RATE)
    ) u_ch (
      .clk         (clk),
      .nrst        (nrst),
      .tick        (tick),
      .raw_pressed (raw_pressed[i]),
      .key_state   (state_v[i]),
      .key_press   (press_v[i]),
      .key_release (release_v[i]),
      .key_repeat  (repeat_v[i])
    );
  end

  assign bus.key_state   = state_v;
  assign bus.key_press   = press_v;
  assign bus.key_release = release_v;
  assign bus.key_repeat  = repeat_v;

endmodule

// File: doc/key_debounce.md
# key_debounce

Input-side companion to the LED pattern driver: conditions raw active-low push-button inputs into clean, debounced key levels and single-cycle press/release event pulses. Sits between the board key pins and any control logic that consumes user input, such as pattern select or speed change. Raw pins are asynchronous to `clk`; every output is synchronous to `clk`.

## Interface
Parameters:
- `N_KEYS`, 4: number of independent key channels.
- `TICK_DIV`, 50000: `clk` cycles per debounce tick (1 ms at 50 MHz); must be ≥ 2.
- `STABLE_TICKS`, 20: consecutive ticks a new level must persist before it is accepted; must be ≥ 1.
- `REPEAT_DELAY`, 500: ticks from accepted press to first repeat pulse (auto-repeat build only).
- `REPEAT_RATE`, 100: ticks between subsequent repeat pulses (auto-repeat build only).

Ports:
- `clk` in 1: single clock, rising edge.
- `nrst` in 1: reset, asynchronous, active-low.
- `key_n` in `N_KEYS`: raw key pins, active-low (0 = pressed), asynchronous.
- `key_state` out `N_KEYS`: debounced level, 1 = pressed.
- `key_press` out `N_KEYS`: one-cycle pulse on accepted press.
- `key_release` out `N_KEYS`: one-cycle pulse on accepted release.
- `key_repeat` out `N_KEYS`: one-cycle auto-repeat pulse; constant 0 unless the auto-repeat build is selected.

## Operation
- Synchronizer: each `key_n` bit passes through 2 flops. The flops reset to 1 (released). The inverted second-flop value is `raw_pressed`.
- Prescaler: a shared counter runs 0..`TICK_DIV`-1 and wraps to 0. `tick` is high for one cycle when the count equals `TICK_DIV`-1. Width is clog2(`TICK_DIV`).
- Per-channel state machine, two states: RELEASED (`key_state`=0) and PRESSED (`key_state`=1). Each channel has a stability counter of width clog2(`STABLE_TICKS`+1).
  - If `raw_pressed` equals `key_state` in any cycle, the counter clears to 0. Glitch rejection is immediate and does not wait for a tick.
  - On a `tick` cycle with `raw_pressed` ≠ `key_state`:
    - If counter = `STABLE_TICKS`-1: `key_state` toggles and the counter clears.
    - Otherwise: the counter increments.
- Event pulses:
  - `key_press[i]` is high for exactly the first cycle in which `key_state[i]`=1.
  - `key_release[i]` is high for exactly the first cycle in which `key_state[i]`=0 after being 1.
  - The pulses are registered together with the `key_state` update.
- Channels are fully independent. Simultaneous transitions on several keys produce simultaneous pulses.

## Timing
- Reset values:
  - `key_state`, `key_press`, `key_release`, `key_repeat` = 0.
  - Prescaler and all channel counters = 0.
  - Synchronizers = 1.
- Reset asserted mid-operation: all outputs drop to 0 asynchronously and no release pulse is generated. A key still held when reset is released produces a normal press pulse after full debounce.
- Latency from a clean level change on `key_n` to the `key_state` update is between 2+(`STABLE_TICKS`-1)·`TICK_DIV`+1 and 2+`STABLE_TICKS`·`TICK_DIV`+1 cycles. The exact value depends on prescaler phase.
- A bounce of any length that returns to the current `key_state` before acceptance produces no output change.
- Prescaler wrap and acceptance in the same cycle are legal. The tick counts normally.

## Configuration
- Macro `KEY_DEBOUNCE_REPEAT_EN`.
- Defined:
  - Each channel has a repeat counter, cleared on the press acceptance cycle.
  - While in PRESSED, the counter increments on each tick.
  - `key_repeat[i]` pulses for one cycle on the tick that reaches `REPEAT_DELAY`, then every `REPEAT_RATE` ticks after that.
  - Release clears the counter. No repeat pulse is issued in the release acceptance cycle.
- Undefined: no repeat logic is generated, and `key_repeat` is tied to 0.

## Structure
- Package `key_debounce_pkg`:
  - channel state enum (RELEASED, PRESSED);
  - width helper constants for the prescaler, stability and repeat counters;
  - default tick constants.
- Top `key_debounce` holds the synchronizers, the shared prescaler, and a generate loop instantiating `N_KEYS` copies of sub-module `key_debounce_ch`.
- `key_debounce_ch` holds the per-key state machine, the stability counter, pulse generation and the optional repeat counter.

## Test plan
Parameters for all scenarios: `TICK_DIV`=4, `STABLE_TICKS`=3, `REPEAT_DELAY`=5, `REPEAT_RATE`=2.
- Clean press: after reset, drive `key_n[0]`=0 and hold → `key_state[0]` rises within 11–15 cycles. `key_press[0]` is high for exactly 1 cycle, coincident with the rise. Other bits stay 0.
- Bounce rejection: toggle `key_n[1]` 0/1 every 5 cycles for 60 cycles, then hold at 1 → `key_state[1]`, `key_press[1]` and `key_release[1]` stay 0 throughout.
- Release: from the pressed state, drive `key_n[0]`=1 → `key_state[0]` falls within 11–15 cycles, with a single `key_release[0]` pulse and no `key_press` pulse.
- Simultaneous keys: drive `key_n`=4'b0000 in the same cycle → all four `key_press` bits pulse in the same cycle.
- Reset mid-debounce: press `key_n[2]`, assert `nrst` after 8 cycles for 3 cycles while the key stays held → outputs are 0 during reset. Exactly one `key_press[2]` pulse follows, 11–15 cycles after `nrst` rises.
- Auto-repeat, with `KEY_DEBOUNCE_REPEAT_EN` defined: hold `key_n[3]`=0 → first `key_repeat[3]` pulse 5 ticks (20 cycles) after press acceptance, then every 8 cycles. There are no repeat pulses after release. Without the macro, `key_repeat` stays 0.
